// File: rtl/puf_rng_word_collector.sv
// Von Neumann debiaser and 64-bit word packer for the ring-oscillator race bits,
// with a sticky repetition-count health test that latches on a stuck source.
module puf_rng_word_collector #(
    parameter int WORD_W    = 64,
    parameter int REP_LIMIT = 32,
    parameter int DROP_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              raw_bit,
    input  logic              raw_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [6:0]        fill_cnt,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              health_fail
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD, FAIL} state_t;

    state_t     state;
    logic       phase_b;
    logic       first_bit;
    logic       last_bit;
    logic [7:0] run_cnt;

    logic       sample;
    logic [7:0] run_next;
    logic       trip;
    logic       corr_valid;
    logic       handshake;

    // Raw bits only count while collecting; a FILL cycle with enable low is a pure exit.
    assign sample     = raw_valid && (((state == FILL) && enable) || (state == HOLD));
    assign run_next   = ((run_cnt == 8'd0) || (raw_bit != last_bit)) ? 8'd1 : run_cnt + 8'd1;
    assign trip       = sample && (run_next == 8'(REP_LIMIT));
    assign corr_valid = sample && phase_b && (raw_bit != first_bit);
    assign handshake  = (state == HOLD) && word_ready;

    // NOTE: all state is registered with non-blocking assignments so every branch
    // below sees the values from before this edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            word_out    <= '0;
            word_valid  <= 1'b0;
            fill_cnt    <= '0;
            drop_cnt    <= '0;
            health_fail <= 1'b0;
            phase_b     <= 1'b0;
            first_bit   <= 1'b0;
            last_bit    <= 1'b0;
            run_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phase_b <= 1'b0;
                    run_cnt <= '0;
                    if (enable && !health_fail)
                        state <= FILL;
                end
                FILL, HOLD: begin
                    if ((state == FILL) && !enable) begin
                        state   <= IDLE;
                        phase_b <= 1'b0;
                        run_cnt <= '0;
                    end else if (trip) begin
                        // A held word is withdrawn; everything else freezes.
                        state       <= FAIL;
                        health_fail <= 1'b1;
                        word_valid  <= 1'b0;
                        run_cnt     <= run_next;
                    end else begin
                        if (sample) begin
                            run_cnt  <= run_next;
                            last_bit <= raw_bit;
                            phase_b  <= !phase_b;
                            if (!phase_b)
                                first_bit <= raw_bit;
                        end
                        if (corr_valid) begin
                            if (state == FILL) begin
                                word_out <= {word_out[WORD_W-2:0], first_bit};
                                fill_cnt <= fill_cnt + 7'd1;
                                if (fill_cnt == 7'(WORD_W - 1)) begin
                                    word_valid <= 1'b1;
                                    state      <= HOLD;
                                end
                            end else if (!(&drop_cnt)) begin
                                drop_cnt <= drop_cnt + 1'b1;
                            end
                        end
                        if (handshake) begin
                            word_valid <= 1'b0;
                            fill_cnt   <= '0;
                            state      <= enable ? FILL : IDLE;
                        end
                    end
                end
                FAIL: state <= FAIL;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_rng_word_collector.sv
// Directed bench for puf_rng_word_collector: a bit-level behavioural model checked
// every cycle, plus hand-computed expectations at each scenario milestone.
module tb_puf_rng_word_collector;

    localparam int WORD_W    = 64;
    localparam int REP_LIMIT = 32;
    localparam int DROP_W    = 4;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              raw_bit;
    logic              raw_valid;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [6:0]        fill_cnt;
    logic [DROP_W-1:0] drop_cnt;
    logic              health_fail;

    int n_checks = 0;
    int n_fails  = 0;

    puf_rng_word_collector #(
        .WORD_W   (WORD_W),
        .REP_LIMIT(REP_LIMIT),
        .DROP_W   (DROP_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .raw_valid  (raw_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill_cnt   (fill_cnt),
        .drop_cnt   (drop_cnt),
        .health_fail(health_fail)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: collecting / holding / failed flags, a pending first bit of
    // the current pair, and the last 64 corrected bits that were accepted into words.
    bit          model_live = 0;
    bit          m_active, m_hold, m_fail;
    int          m_pend;
    int          m_run;
    bit          m_last;
    int          m_fill, m_drop;
    logic [63:0] m_word;

    always @(posedge clock) begin
        model_live = 1;
        if (reset) begin
            m_active = 0; m_hold = 0; m_fail = 0;
            m_pend = -1; m_run = 0; m_last = 0;
            m_fill = 0; m_drop = 0; m_word = '0;
        end else if (m_fail) begin
            // frozen
        end else if (!m_active) begin
            m_pend = -1;
            m_run  = 0;
            if (enable) m_active = 1;
        end else if (!m_hold && !enable) begin
            m_active = 0;
            m_pend   = -1;
            m_run    = 0;
        end else begin
            int  corr;
            bit  tripped;
            corr    = -1;
            tripped = 0;
            if (raw_valid) begin
                m_run  = (m_run == 0 || raw_bit != m_last) ? 1 : m_run + 1;
                m_last = raw_bit;
                if (m_run == REP_LIMIT) tripped = 1;
                if (!tripped) begin
                    if (m_pend < 0) m_pend = int'(raw_bit);
                    else begin
                        if (m_pend != int'(raw_bit)) corr = m_pend;
                        m_pend = -1;
                    end
                end
            end
            if (tripped) begin
                m_fail = 1;
                m_hold = 0;
            end else begin
                bit hs;
                hs = m_hold && word_ready;
                if (corr >= 0) begin
                    if (m_hold) begin
                        if (m_drop < (1 << DROP_W) - 1) m_drop++;
                    end else begin
                        m_word = (m_word << 1) | 64'(corr);
                        m_fill++;
                        if (m_fill == WORD_W) m_hold = 1;
                    end
                end
                if (hs) begin
                    m_hold = 0;
                    m_fill = 0;
                    if (!enable) m_active = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_live) begin
            check("word_out",    word_out,    m_word);
            check("word_valid",  word_valid,  64'(m_hold));
            check("fill_cnt",    fill_cnt,    64'(m_fill));
            check("drop_cnt",    drop_cnt,    64'(m_drop));
            check("health_fail", health_fail, 64'(m_fail));
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_raw(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        cycle(1);
        raw_valid = 1'b0;
    endtask

    // Corrected bit c comes from the raw pair (c, !c).
    task automatic send_pair(input logic c);
        send_raw(c);
        send_raw(!c);
    endtask

    task automatic accept_word();
        word_ready = 1'b1;
        cycle(1);
        word_ready = 1'b0;
    endtask

    logic [19:0] pat_p;
    logic [43:0] pat_q;

    initial begin
        pat_p      = 20'hB3C5A;
        pat_q      = 44'h123456789AB;
        enable     = 1'b0;
        raw_bit    = 1'b0;
        raw_valid  = 1'b0;
        word_ready = 1'b0;
        reset      = 1'b1;
        cycle(2);
        reset = 1'b0;
        check("rst word_valid",  word_valid,  64'd0);
        check("rst fill_cnt",    fill_cnt,    64'd0);
        check("rst drop_cnt",    drop_cnt,    64'd0);
        check("rst health_fail", health_fail, 64'd0);
        check("rst word_out",    word_out,    64'd0);

        // 64 pairs of 0,1: word_valid must rise exactly on the 128th raw_valid edge
        enable = 1'b1;
        cycle(1);
        for (int i = 0; i < 63; i++) send_pair(1'b0);
        send_raw(1'b0);
        check("t1 valid before last", word_valid, 64'd0);
        send_raw(1'b1);
        check("t1 word_valid", word_valid, 64'd1);
        check("t1 word_out",   word_out,   64'h0);
        check("t1 fill_cnt",   fill_cnt,   64'd64);
        accept_word();
        check("t1 hs valid", word_valid, 64'd0);
        check("t1 hs fill",  fill_cnt,   64'd0);

        // Alternating corrected 1,0 -> 0xAAAA..., then drops while held
        for (int i = 0; i < 64; i++) send_pair(i % 2 == 0);
        check("t2 word_out", word_out,   64'hAAAAAAAAAAAAAAAA);
        check("t2 valid",    word_valid, 64'd1);
        for (int i = 0; i < 10; i++) send_pair(1'b1);
        check("t3 word_out held", word_out, 64'hAAAAAAAAAAAAAAAA);
        check("t3 drop_cnt 10",   drop_cnt, 64'd10);
        send_raw(1'b0); send_raw(1'b0);
        send_raw(1'b1); send_raw(1'b1);
        check("t3 drop after discard", drop_cnt, 64'd10);
        for (int i = 0; i < 8; i++) send_pair(1'b1);
        check("t3 drop saturated", drop_cnt, 64'd15);
        accept_word();
        check("t3 hs valid", word_valid, 64'd0);
        check("t3 hs fill",  fill_cnt,   64'd0);

        // Partial word survives an enable drop
        for (int i = 19; i >= 0; i--) send_pair(pat_p[i]);
        check("t4 fill 20", fill_cnt, 64'd20);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) send_raw(k[0]);
        check("t4 fill retained", fill_cnt, 64'd20);
        enable = 1'b1;
        cycle(1);
        for (int i = 43; i >= 0; i--) send_pair(pat_q[i]);
        check("t4 valid",      word_valid,      64'd1);
        check("t4 upper bits", word_out[63:44], 64'(pat_p));
        check("t4 word_out",   word_out,        64'hB3C5A123456789AB);
        accept_word();

        // Repetition health test
        for (int i = 0; i < REP_LIMIT - 1; i++) send_raw(1'b1);
        check("t5 no trip at 31", health_fail, 64'd0);
        send_raw(1'b1);
        check("t5 health_fail", health_fail, 64'd1);
        check("t5 word_valid",  word_valid,  64'd0);
        for (int i = 0; i < 4; i++) send_pair(1'b1);
        accept_word();
        check("t5 fill frozen", fill_cnt,    64'd0);
        check("t5 word frozen", word_out,    64'hB3C5A123456789AB);
        check("t5 still fail",  health_fail, 64'd1);
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        check("t5 reset clears fail", health_fail, 64'd0);
        check("t5 reset word",        word_out,    64'd0);

        // Reset coinciding with a handshake
        cycle(1);
        for (int i = 0; i < 64; i++) send_pair(i[0]);
        check("t6 valid", word_valid, 64'd1);
        for (int i = 0; i < 3; i++) send_pair(1'b1);
        check("t6 drop 3", drop_cnt, 64'd3);
        word_ready = 1'b1;
        reset      = 1'b1;
        cycle(1);
        word_ready = 1'b0;
        reset      = 1'b0;
        check("t6 valid",  word_valid, 64'd0);
        check("t6 fill",   fill_cnt,   64'd0);
        check("t6 drop",   drop_cnt,   64'd0);
        check("t6 word",   word_out,   64'd0);
        check("t6 health", health_fail, 64'd0);
        cycle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
